// File: rtl/idma_burst_arbiter_if.sv
// Frontend/backend burst handshake bundle for idma_burst_arbiter.
// The arbiter uses the slave view; the environment (frontends + backend) uses master.
interface idma_burst_arbiter_if #(
    parameter int unsigned NumReq      = 4,
    parameter type         burst_req_t = logic
);
    burst_req_t              req_burst [NumReq];
    logic [NumReq-1:0]       req_valid;
    logic [NumReq-1:0]       req_ready;
    logic [NumReq-1:0]       req_complete;
    burst_req_t              burst_req;
    logic                    valid;
    logic                    ready;
    logic                    trans_complete;

    modport slave (
        input  req_burst, req_valid, ready, trans_complete,
        output req_ready, req_complete, burst_req, valid
    );

    modport master (
        output req_burst, req_valid, ready, trans_complete,
        input  req_ready, req_complete, burst_req, valid
    );
endinterface

// File: rtl/idma_burst_arbiter.sv
// Round-robin arbiter sharing one iDMA backend between NumReq frontends, with an
// in-order FIFO routing each backend completion back to its issuing frontend.
module idma_burst_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    idma_burst_arbiter_if.slave               bus,
    input  logic                              backend_idle_i,
    output logic                              idle_o,
    output logic [$clog2(MaxOutstanding):0]   outstanding_o,
    output logic                              spurious_o
);
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    typedef enum logic {UNLOCKED, LOCKED} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] locked_q, locked_d;
    logic [IdxW-1:0] prio_q, prio_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            spurious_q, spurious_d;

    logic            found;
    logic [IdxW-1:0] grant;
    logic [IdxW-1:0] cand;
    int unsigned     idx;
    logic            push;
    logic            pop;

    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        idx   = 0;
        if (state_q == LOCKED) begin
            found = 1'b1;
            grant = locked_q;
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                idx  = (32'(prio_q) + i) % NumReq;
                cand = IdxW'(idx);
                if (!found && bus.req_valid[cand]) begin
                    found = 1'b1;
                    grant = cand;
                end
            end
        end
    end

    // Outputs are forced low while in reset, even before the first clock edge clears state.
    always_comb begin
        bus.valid        = rst_ni & found & bus.req_valid[grant] & (count_q < FullCnt);
        bus.burst_req    = rst_ni ? bus.req_burst[grant] : '0;
        push             = bus.valid & bus.ready;
        pop              = rst_ni & bus.trans_complete & (count_q != '0);
        bus.req_ready    = '0;
        bus.req_complete = '0;
        if (push) bus.req_ready[grant] = 1'b1;
        if (pop)  bus.req_complete[fifo_q[rd_ptr_q]] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        locked_d   = locked_q;
        prio_d     = prio_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        spurious_d = spurious_q | (bus.trans_complete & (count_q == '0));

        case (state_q)
            UNLOCKED: if (bus.valid && !bus.ready) begin
                state_d  = LOCKED;
                locked_d = grant;
            end
            LOCKED:   if (push) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
        endcase

        if (push) begin
            prio_d   = (grant == LastIdx) ? '0 : grant + IdxW'(1);
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= UNLOCKED;
            locked_q   <= '0;
            prio_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            locked_q   <= locked_d;
            prio_q     <= prio_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
        end
    end

    // Storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) fifo_q[wr_ptr_q] <= grant;
    end

    assign outstanding_o = count_q;
    assign spurious_o    = spurious_q;
    assign idle_o        = (count_q == '0) & backend_idle_i & ~(|bus.req_valid) &
                           (state_q == UNLOCKED);
endmodule

// File: tb/tb_idma_burst_arbiter.sv
// Directed self-checking bench for idma_burst_arbiter (4 frontends, 8 outstanding).
module tb_idma_burst_arbiter;
    logic       clk = 1'b0;
    logic       rst_ni;
    logic       backend_idle;
    logic       idle;
    logic [3:0] outstanding;
    logic       spurious;
    int         checks = 0;
    int         failures = 0;

    idma_burst_arbiter_if #(.NumReq(4), .burst_req_t(logic [7:0])) bus ();

    idma_burst_arbiter #(.NumReq(4), .MaxOutstanding(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .bus            (bus),
        .backend_idle_i (backend_idle),
        .idle_o         (idle),
        .outstanding_o  (outstanding),
        .spurious_o     (spurious)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic rdy, input logic tc);
        bus.req_valid      = v;
        bus.ready          = rdy;
        bus.trans_complete = tc;
        #1;
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        backend_idle = 1'b1;
        drive(4'b0000, 1'b1, 1'b0);
        tick();
        checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        checks++; if (spurious !== 1'b0) begin failures++; $display("FAIL reset_spurious got=%b exp=0", spurious); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
        drive(4'b1111, 1'b1, 1'b1);
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.req_complete !== 4'b0000) begin failures++; $display("FAIL reset_req_complete got=%b exp=0000", bus.req_complete); end
        checks++; if (bus.burst_req !== 8'h00) begin failures++; $display("FAIL reset_burst got=%h exp=00", bus.burst_req); end
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        drive(4'b0100, 1'b1, 1'b0);
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
        checks++; if (bus.burst_req !== 8'hA2) begin failures++; $display("FAIL single_burst got=%h exp=a2", bus.burst_req); end
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", idle); end
        tick();
        drive(4'b0000, 1'b0, 1'b1);
        checks++; if (outstanding !== 4'd1) begin failures++; $display("FAIL single_out1 got=%0d exp=1", outstanding); end
        checks++; if (bus.req_complete !== 4'b0100) begin failures++; $display("FAIL single_complete got=%b exp=0100", bus.req_complete); end
        tick();
        drive(4'b0000, 1'b0, 1'b0);
        checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL single_out0 got=%0d exp=0", outstanding); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", idle); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_ready [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] exp_burst [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b1, 1'b0);
            checks++; if (bus.req_ready !== exp_ready[i]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, bus.req_ready, exp_ready[i]); end
            checks++; if (bus.burst_req !== exp_burst[i]) begin failures++; $display("FAIL rr_burst%0d got=%h exp=%h", i, bus.burst_req, exp_burst[i]); end
            tick();
        end
        drive(4'b0000, 1'b0, 1'b0);
        checks++; if (outstanding !== 4'd5) begin failures++; $display("FAIL rr_out got=%0d exp=5", outstanding); end
        for (int i = 0; i < 5; i++) begin
            drive(4'b0000, 1'b0, 1'b1);
            checks++; if (bus.req_complete !== exp_ready[i]) begin failures++; $display("FAIL rr_complete%0d got=%b exp=%b", i, bus.req_complete, exp_ready[i]); end
            tick();
        end
        drive(4'b0000, 1'b0, 1'b0);
        checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL rr_drained got=%0d exp=0", outstanding); end
    endtask

    task automatic test_lock;
        do_reset();
        drive(4'b0010, 1'b0, 1'b0);
        checks++; if (bus.valid !== 1'b1 || bus.burst_req !== 8'hA1) begin failures++; $display("FAIL lock_first got=%b/%h exp=1/a1", bus.valid, bus.burst_req); end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(4'b0011, 1'b0, 1'b0);
            checks++; if (bus.burst_req !== 8'hA1) begin failures++; $display("FAIL lock_hold_burst%0d got=%h exp=a1", i, bus.burst_req); end
            checks++; if (bus.valid !== 1'b1 || bus.req_ready !== 4'b0000) begin failures++; $display("FAIL lock_hold_valid%0d got=%b/%b exp=1/0000", i, bus.valid, bus.req_ready); end
            tick();
        end
        drive(4'b0011, 1'b1, 1'b0);
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL lock_handshake got=%b exp=0010", bus.req_ready); end
        tick();
        drive(4'b0001, 1'b1, 1'b0);
        checks++; if (bus.req_ready !== 4'b0001 || bus.burst_req !== 8'hA0) begin failures++; $display("FAIL lock_next got=%b/%h exp=0001/a0", bus.req_ready, bus.burst_req); end
        tick();
        drive(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b0001, 1'b1, 1'b0);
            tick();
        end
        drive(4'b0001, 1'b1, 1'b0);
        checks++; if (outstanding !== 4'd8) begin failures++; $display("FAIL full_out got=%0d exp=8", outstanding); end
        checks++; if (bus.valid !== 1'b0 || bus.req_ready !== 4'b0000) begin failures++; $display("FAIL full_block got=%b/%b exp=0/0000", bus.valid, bus.req_ready); end
        drive(4'b0001, 1'b1, 1'b1);
        checks++; if (bus.req_complete !== 4'b0001 || bus.valid !== 1'b0) begin failures++; $display("FAIL full_pop got=%b/%b exp=0001/0", bus.req_complete, bus.valid); end
        tick();
        drive(4'b0001, 1'b1, 1'b0);
        checks++; if (outstanding !== 4'd7) begin failures++; $display("FAIL full_out7 got=%0d exp=7", outstanding); end
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL full_reissue got=%b exp=0001", bus.req_ready); end
        tick();
        drive(4'b0000, 1'b0, 1'b0);
        checks++; if (outstanding !== 4'd8) begin failures++; $display("FAIL full_refill got=%0d exp=8", outstanding); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        drive(4'b0010, 1'b1, 1'b0);
        tick();
        drive(4'b1000, 1'b1, 1'b1);
        checks++; if (bus.req_complete !== 4'b0010) begin failures++; $display("FAIL b2b_complete_old got=%b exp=0010", bus.req_complete); end
        checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL b2b_issue got=%b exp=1000", bus.req_ready); end
        tick();
        drive(4'b0000, 1'b0, 1'b1);
        checks++; if (outstanding !== 4'd1) begin failures++; $display("FAIL b2b_out got=%0d exp=1", outstanding); end
        checks++; if (bus.req_complete !== 4'b1000) begin failures++; $display("FAIL b2b_complete_new got=%b exp=1000", bus.req_complete); end
        tick();
        drive(4'b0000, 1'b0, 1'b0);
        checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL b2b_drained got=%0d exp=0", outstanding); end
    endtask

    task automatic test_spurious_reset;
        do_reset();
        drive(4'b0000, 1'b0, 1'b1);
        checks++; if (bus.req_complete !== 4'b0000) begin failures++; $display("FAIL spur_nopulse got=%b exp=0000", bus.req_complete); end
        tick();
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        checks++; if (spurious !== 1'b1 || outstanding !== 4'd0) begin failures++; $display("FAIL spur_sticky got=%b/%0d exp=1/0", spurious, outstanding); end
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b1, 1'b0);
            tick();
        end
        drive(4'b0100, 1'b1, 1'b0);
        checks++; if (outstanding !== 4'd3) begin failures++; $display("FAIL spur_out3 got=%0d exp=3", outstanding); end
        rst_ni = 1'b0;
        #1;
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", bus.valid); end
        tick();
        checks++; if (outstanding !== 4'd0 || spurious !== 1'b0) begin failures++; $display("FAIL rst_mid_clear got=%0d/%b exp=0/0", outstanding, spurious); end
        rst_ni = 1'b1;
        drive(4'b0000, 1'b0, 1'b1);
        checks++; if (bus.req_complete !== 4'b0000) begin failures++; $display("FAIL rst_stale_pulse got=%b exp=0000", bus.req_complete); end
        tick();
        drive(4'b0000, 1'b0, 1'b0);
        checks++; if (spurious !== 1'b1) begin failures++; $display("FAIL rst_stale_spur got=%b exp=1", spurious); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bus.req_burst[i] = 8'hA0 + 8'(i);
        rst_ni = 1'b0;
        backend_idle = 1'b1;
        bus.req_valid = '0;
        bus.ready = 1'b0;
        bus.trans_complete = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_full();
        test_back_to_back();
        test_spurious_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/idma_burst_arbiter.md
Name: idma_burst_arbiter

Overview:
- Shares one iDMA backend between NumReq independent frontends (e.g. several 64-bit register frontends, one per device).
- Arbitrates burst requests round-robin and holds each grant stable until the backend handshake completes.
- Records the requester of every issued burst in an in-order tracking FIFO, so each backend completion pulse is routed back to the frontend that issued it.
- Sits between the frontends' burst_req/valid/ready/trans_complete signals and the backend's matching signals.

Parameters:
- NumReq, 4, number of requesting frontends (>=2).
- MaxOutstanding, 8, depth of the completion-tracking FIFO (power of two, >=2).
- burst_req_t, logic, dma burst request type (passed through unmodified).

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset; synchronous, active-low.
- req_burst_i  in  NumReq x burst_req_t  burst request from each frontend.
- req_valid_i  in  NumReq  request valid per frontend.
- req_ready_o  out  NumReq  request accepted per frontend.
- req_complete_o  out  NumReq  one-cycle completion pulse per frontend.
- burst_req_o  out  burst_req_t  request to backend.
- valid_o  out  1  request valid to backend.
- ready_i  in  1  backend ready.
- trans_complete_i  in  1  backend completion pulse (in issue order).
- backend_idle_i  in  1  backend idle.
- idle_o  out  1  arbiter and backend fully idle.
- outstanding_o  out  $clog2(MaxOutstanding)+1  issued, not yet completed bursts.
- spurious_o  out  1  sticky: trans_complete_i seen with FIFO empty.

Behaviour:
- Reset (rst_ni low at clk_i edge) clears:
  - priority pointer to 0;
  - lock flag and locked index;
  - FIFO read/write pointers and count to 0;
  - spurious_o to 0.
- While in reset, all outputs are 0: valid_o, req_ready_o, req_complete_o, outstanding_o, spurious_o, burst_req_o='0. idle_o follows its formula (count=0, unlocked), so it equals backend_idle_i.
- Reset mid-operation discards all tracking; later completions count as spurious.
- States:
  - UNLOCKED: grant = first requester with req_valid_i set, searching from the priority pointer upward and wrapping at NumReq.
  - LOCKED: grant = registered locked index; req_valid_i of the other requesters is ignored.
- Combinational path (zero latency):
  - burst_req_o = req_burst_i[grant].
  - valid_o = req_valid_i[grant] & (grant exists) & (count < MaxOutstanding).
  - req_ready_o[grant] = ready_i & valid_o. All other req_ready_o bits are 0.
- UNLOCKED -> LOCKED: valid_o=1 and ready_i=0; latch grant as locked index.
- LOCKED -> UNLOCKED: on handshake (valid_o & ready_i).
- Frontends must hold valid and data stable until ready; the arbiter relies on this.
- Full handling:
  - When count == MaxOutstanding, no new grant is presented: valid_o=0, all req_ready_o=0.
  - The FIFO only fills on a handshake, so an asserted valid_o is never withdrawn.
- On handshake:
  - push grant index into the FIFO;
  - priority pointer <= (grant+1) mod NumReq.
  - The pointer is unchanged when there is no handshake.
- On trans_complete_i with count>0:
  - req_complete_o[FIFO head] = 1 in the same cycle (combinational);
  - pop the head at the clock edge.
- On trans_complete_i with count==0: no pulse, no pop; spurious_o <= 1 until reset.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - The popped entry is the old head, even when count==1.
  - Push at full cannot occur.
- Pointers wrap modulo MaxOutstanding; count has $clog2(MaxOutstanding)+1 bits.
- outstanding_o = count (registered).
- idle_o = (count==0) & backend_idle_i & ~(|req_valid_i) & unlocked.

Test Plan:
- Single requester: req 2 valid, ready_i=1 -> same-cycle handshake, req_ready_o=4'b0100, outstanding_o 0->1; then trans_complete_i -> req_complete_o=4'b0100, outstanding_o->0.
- Round-robin fairness: all 4 valid continuously, ready_i=1, pointer 0 -> grants in order 0,1,2,3,0; FIFO contents match; completions pulse bits 0,1,2,3 in order.
- Grant lock: req 1 valid, ready_i=0 for 3 cycles, req 0 asserts during the stall -> burst_req_o stays req 1's data, valid_o stays 1; req 0 is granted the cycle after req 1's handshake.
- Full: 8 handshakes with no completions -> outstanding_o=8, valid_o=0 despite requests; one trans_complete_i -> outstanding_o=7, next request issues.
- Simultaneous issue and completion at count=1 -> outstanding_o stays 1; complete pulse goes to the older requester; the new requester's index becomes head.
- Spurious and reset: trans_complete_i with count=0 -> no req_complete_o pulse, spurious_o=1 sticky; assert rst_ni=0 with 3 outstanding -> next cycle outstanding_o=0, spurious_o=0, valid_o=0.
